// File: rtl/nway_cache_control_pkg.sv
// Shared types and helpers for the N-way cache controller.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  // Datapath write-source select
  localparam logic [1:0] DS_FILL = 2'b00;
  localparam logic [1:0] DS_CPU  = 2'b01;
  localparam logic [1:0] DS_NONE = 2'b11;

  // Way index width that never collapses to zero bits
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nway_cache_control_if.sv
// CPU-side request handshake plus pmem burst handshake.
// master: the CPU/memory side; slave: the cache controller.
interface nway_cache_control_if;
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic pmem_resp;
  logic pmem_read;
  logic pmem_write;

  modport master (output mem_read, mem_write, pmem_resp,
                  input  mem_resp, pmem_read, pmem_write);
  modport slave  (input  mem_read, mem_write, pmem_resp,
                  output mem_resp, pmem_read, pmem_write);
endinterface

// File: rtl/nway_cache_control_plru.sv
// Tree-PLRU helper: heap-indexed tree, node 0 is the root,
// a bit of 0 means the victim lies in the lower-index subtree.
module plru_tree
  import cache_ctrl_pkg::*;
#(
  parameter  int WAYS = 4,
  localparam int IW   = idx_w(WAYS)
) (
  input  logic [WAYS-2:0] lru_in,
  input  logic [IW-1:0]   acc_way,
  output logic [WAYS-2:0] lru_out,
  output logic [IW-1:0]   victim
);

  // Walk the accessed way's path and point every node away from it
  always_comb begin
    int n;
    n       = 0;
    lru_out = lru_in;
    for (int l = 0; l < IW; l++) begin
      lru_out[n] = ~acc_way[IW-1-l];
      n = 2 * n + 1 + int'(acc_way[IW-1-l]);
    end
  end

  // Follow the tree bits from the root down to the victim leaf
  always_comb begin
    int   n;
    logic b;
    n      = 0;
    b      = 1'b0;
    victim = '0;
    for (int l = 0; l < IW; l++) begin
      b = lru_in[n];
      victim[IW-1-l] = b;
      n = 2 * n + 1 + int'(b);
    end
  end

endmodule

// File: rtl/nway_cache_control.sv
// Control FSM for an N-way set-associative write-back cache with
// tree-PLRU replacement and saturating hit/miss/write-back counters.
module nway_cache_control
  import cache_ctrl_pkg::*;
#(
  parameter  int WAYS  = 4,
  parameter  int CNT_W = 32,
  localparam int IW    = idx_w(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  nway_cache_control_if.slave bus,
  input  logic [WAYS-1:0]  hit_way,
  input  logic [WAYS-1:0]  valid_way,
  input  logic [WAYS-1:0]  dirty_way,
  input  logic [WAYS-2:0]  lru_in,
  output logic             lru_load,
  output logic [WAYS-2:0]  lru_out,
  output logic [IW-1:0]    way_sel,
  output logic             tag_load,
  output logic             valid_load,
  output logic             dirty_load,
  output logic             dirty_in,
  output logic [1:0]       data_sel,
  output logic             wb_addr_sel,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  state_t          state;
  logic [IW-1:0]   victim_q;
  logic [IW-1:0]   hit_idx;
  logic [IW-1:0]   plru_victim;
  logic [IW-1:0]   miss_victim;
  logic [WAYS-2:0] lru_next;
  logic            req;
  logic            hit;
  logic            victim_dirty;

  // Requests are masked during reset so no strobe can leak out
  assign req          = (bus.mem_read | bus.mem_write) & rst_n;
  assign hit          = |hit_way;
  assign victim_dirty = valid_way[miss_victim] & dirty_way[miss_victim];

  plru_tree #(.WAYS(WAYS)) u_plru (
    .lru_in  (lru_in),
    .acc_way (hit_idx),
    .lru_out (lru_next),
    .victim  (plru_victim)
  );

  // Lowest-index hitting way wins if more than one matches
  always_comb begin
    hit_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (hit_way[i]) hit_idx = IW'(i);
  end

  // Fill an empty way first; only evict by PLRU when the set is full
  always_comb begin
    miss_victim = plru_victim;
    for (int i = WAYS - 1; i >= 0; i--)
      if (!valid_way[i]) miss_victim = IW'(i);
  end

  // State, registered victim and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CHECK;
      victim_q <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      case (state)
        CHECK: if (req) begin
          if (hit) begin
            if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + CNT_W'(1);
          end else begin
            victim_q <= miss_victim;
            if (miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + CNT_W'(1);
            state <= victim_dirty ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: if (bus.pmem_resp) begin
          if (wb_cnt != {CNT_W{1'b1}}) wb_cnt <= wb_cnt + CNT_W'(1);
          state <= FILL;
        end
        FILL: if (bus.pmem_resp) state <= CHECK;
        default: state <= CHECK;
      endcase
    end
  end

  // Datapath strobes; hits complete in the same cycle as the request
  always_comb begin
    bus.mem_resp   = 1'b0;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    lru_load       = 1'b0;
    lru_out        = '0;
    way_sel        = victim_q;
    tag_load       = 1'b0;
    valid_load     = 1'b0;
    dirty_load     = 1'b0;
    dirty_in       = 1'b0;
    data_sel       = DS_NONE;
    wb_addr_sel    = 1'b0;
    case (state)
      CHECK: if (req && hit) begin
        bus.mem_resp = 1'b1;
        way_sel      = hit_idx;
        lru_load     = 1'b1;
        lru_out      = lru_next;
        if (bus.mem_write) begin
          dirty_load = 1'b1;
          dirty_in   = 1'b1;
          data_sel   = DS_CPU;
        end
      end
      WRITEBACK: begin
        bus.pmem_write = 1'b1;
        wb_addr_sel    = 1'b1;
      end
      FILL: begin
        bus.pmem_read = 1'b1;
        data_sel      = DS_FILL;
        if (bus.pmem_resp) begin
          tag_load   = 1'b1;
          valid_load = 1'b1;
          dirty_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A tag array should never report more than one matching way
  hit_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state == CHECK && req) |-> $onehot0(hit_way));

endmodule
